// File: rtl/crtc_timing_gen.sv
// crtc_timing_gen: MC6845-style raster timing engine (non-interlaced) producing sync, enable, MA/RA and cursor
module crtc_timing_gen #(
    parameter int MA_W        = 14,
    parameter int RA_W        = 5,
    parameter int VSYNC_LINES = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [7:0]      R0_HTOTAL,
    input  logic [7:0]      R1_HDISP,
    input  logic [7:0]      R2_HSPOS,
    input  logic [3:0]      R3_HSW,
    input  logic [6:0]      R4_VTOTAL,
    input  logic [4:0]      R5_VADJ,
    input  logic [6:0]      R6_VDISP,
    input  logic [6:0]      R7_VSPOS,
    input  logic [RA_W-1:0] R9_MAXSL,
    input  logic [6:0]      R10_CSTART,
    input  logic [RA_W-1:0] R11_CEND,
    input  logic [MA_W-1:0] R12_START,
    input  logic [MA_W-1:0] R14_CURSOR,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DE,
    output logic [MA_W-1:0] MA,
    output logic [RA_W-1:0] RA,
    output logic            CURSOR
);
    localparam int VW = $clog2(VSYNC_LINES + 1);

    typedef enum logic {ROWS, ADJ} state_t;

    state_t          state, state_n;
    logic [7:0]      hcc, hcc_n;
    logic [RA_W-1:0] ra, ra_n;
    logic [6:0]      vcc, vcc_n;
    logic [4:0]      hcnt, hcnt_n;
    logic [VW-1:0]   vcnt, vcnt_n;
    logic [MA_W-1:0] ma_row, ma_row_n, ma_n;
    logic [4:0]      fc, fc_n;
    logic            eol, restart, blink;
    logic            hsync_n, vsync_n, de_n, cursor_n;

    // counters and registered outputs advance on the falling character clock edge
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ROWS;
            hcc    <= '0;
            ra     <= '0;
            vcc    <= '0;
            hcnt   <= '0;
            vcnt   <= '0;
            ma_row <= '0;
            fc     <= '0;
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
            DE     <= 1'b0;
            MA     <= '0;
            RA     <= '0;
            CURSOR <= 1'b0;
        end else begin
            state  <= state_n;
            hcc    <= hcc_n;
            ra     <= ra_n;
            vcc    <= vcc_n;
            hcnt   <= hcnt_n;
            vcnt   <= vcnt_n;
            ma_row <= ma_row_n;
            fc     <= fc_n;
            HSYNC  <= hsync_n;
            VSYNC  <= vsync_n;
            DE     <= de_n;
            MA     <= ma_n;
            RA     <= ra_n;
            CURSOR <= cursor_n;
        end
    end

    // next counter state; RA doubles as the adjust-line counter while in ADJ
    always_comb begin
        eol      = hcc == R0_HTOTAL;
        hcc_n    = eol ? 8'd0 : hcc + 8'd1;
        state_n  = state;
        ra_n     = ra;
        vcc_n    = vcc;
        ma_row_n = ma_row;
        fc_n     = fc;
        restart  = 1'b0;
        if (eol) begin
            if (state == ADJ) begin
                ra_n    = ra + RA_W'(1);
                restart = ({1'b0, ra} + (RA_W+1)'(1)) >= (RA_W+1)'(R5_VADJ);
            end else if (ra != R9_MAXSL) begin
                ra_n = ra + RA_W'(1);
            end else begin
                ra_n = '0;
                if (vcc != R4_VTOTAL) begin
                    vcc_n    = vcc + 7'd1;
                    ma_row_n = ma_row + MA_W'(R1_HDISP);
                end else if (R5_VADJ != 5'd0) begin
                    state_n = ADJ;
                end else begin
                    restart = 1'b1;
                end
            end
            if (restart) begin
                state_n  = ROWS;
                ra_n     = '0;
                vcc_n    = '0;
                ma_row_n = R12_START;
                fc_n     = fc + 5'd1;
            end
        end
        hcnt_n = (hcc_n == R2_HSPOS) ? ((R3_HSW == 4'd0) ? 5'd16 : {1'b0, R3_HSW})
               : (hcnt != 5'd0) ? hcnt - 5'd1 : 5'd0;
        vcnt_n = !eol ? vcnt
               : (state_n == ROWS && ra_n == '0 && vcc_n == R7_VSPOS) ? VW'(VSYNC_LINES)
               : (vcnt != '0) ? vcnt - VW'(1) : vcnt;
    end

    // next output values, derived from the next counter state so outputs match the counters of their cycle
    always_comb begin
        ma_n     = ma_row_n + MA_W'(hcc_n);
        de_n     = hcc_n < R1_HDISP && vcc_n < R6_VDISP && state_n == ROWS;
        blink    = R10_CSTART[6] ? (R10_CSTART[5] ? fc_n[4] : fc_n[3]) : !R10_CSTART[5];
        cursor_n = de_n && ma_n == R14_CURSOR && ra_n >= R10_CSTART[4:0] && ra_n <= R11_CEND && blink;
        hsync_n  = hcnt_n != 5'd0;
        vsync_n  = vcnt_n != '0;
    end
endmodule

// File: tb/tb_crtc_timing_gen.sv
// tb_crtc_timing_gen: randomized and directed raster checks against a frame-arithmetic reference model
module tb_crtc_timing_gen;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  r0, r1, r2;
    logic [3:0]  r3;
    logic [6:0]  r4, r6, r7, r10;
    logic [4:0]  r5, r9, r11;
    logic [13:0] r12, r14;
    logic        HSYNC, VSYNC, DE, CURSOR;
    logic [13:0] MA;
    logic [4:0]  RA;
    int          passed = 0;
    int          total = 0;

    crtc_timing_gen dut (
        .CLK(CLK), .RST(RST),
        .R0_HTOTAL(r0), .R1_HDISP(r1), .R2_HSPOS(r2), .R3_HSW(r3),
        .R4_VTOTAL(r4), .R5_VADJ(r5), .R6_VDISP(r6), .R7_VSPOS(r7),
        .R9_MAXSL(r9), .R10_CSTART(r10), .R11_CEND(r11),
        .R12_START(r12), .R14_CURSOR(r14),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .MA(MA), .RA(RA), .CURSOR(CURSOR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // position of absolute scanline n (counted from reset) within the frame structure
    function automatic void line_pos(input int n, output int row, output int ra, output int f, output bit adj);
        int rl, fl, l;
        rl  = (int'(r4) + 1) * (int'(r9) + 1);
        fl  = rl + int'(r5);
        f   = n / fl;
        l   = n % fl;
        adj = l >= rl;
        row = adj ? int'(r4) : l / (int'(r9) + 1);
        ra  = adj ? l - rl : l % (int'(r9) + 1);
    endfunction

    // expected {HSYNC,VSYNC,DE,CURSOR,RA,MA} for cycle k after reset release
    function automatic logic [22:0] model(input int k);
        int hl, h, n, row, ra, f, w, rw, raw, fw, ma;
        bit adj, aw, hs, vs, de, cur, bl;
        logic [4:0] fm;
        if (k == 0) return '0;
        hl = int'(r0) + 1;
        h  = k % hl;
        n  = k / hl;
        w  = (r3 == 4'd0) ? 16 : int'(r3);
        hs = 0;
        for (int j = 0; j < w; j++)
            if (k - j >= 1 && (k - j) % hl == int'(r2)) hs = 1;
        vs = 0;
        for (int m = n - 15; m <= n; m++)
            if (m >= 1) begin
                line_pos(m, rw, raw, fw, aw);
                if (!aw && raw == 0 && rw == int'(r7)) vs = 1;
            end
        line_pos(n, row, ra, f, adj);
        ma  = ((f == 0 ? 0 : int'(r12)) + row * int'(r1) + h) % 16384;
        de  = h < int'(r1) && row < int'(r6) && !adj;
        fm  = 5'(f);
        case (r10[6:5])
            2'b00: bl = 1;
            2'b01: bl = 0;
            2'b10: bl = fm[3];
            default: bl = fm[4];
        endcase
        cur = de && ma == int'(r14) && ra >= int'(r10[4:0]) && ra <= int'(r11) && bl;
        return {hs, vs, de, cur, 5'(ra), 14'(ma)};
    endfunction

    task automatic run(input string tag, input int cycles, input int rst_at);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k <= cycles; k++) begin
            check($sformatf("%s@%0d", tag, k), 32'({HSYNC, VSYNC, DE, CURSOR, RA, MA}), 32'(model(k)));
            if (k == rst_at) begin
                RST = 1'b1;
                #1;
                check($sformatf("%s_async_rst", tag), 32'({HSYNC, VSYNC, DE, CURSOR, RA, MA}), 32'd0);
                break;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic spec_cfg();
        r0 = 8'd9;  r1 = 8'd6;  r2 = 8'd7;  r3 = 4'd2;
        r4 = 7'd7;  r5 = 5'd2;  r6 = 7'd5;  r7 = 7'd6;
        r9 = 5'd3;  r10 = 7'h01; r11 = 5'd2;
        r12 = 14'h100; r14 = 14'h102;
    endtask

    initial begin
        int cyc;
        spec_cfg();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_held", 32'({HSYNC, VSYNC, DE, CURSOR, RA, MA}), 32'd0);
        run("spec", 700, 344);
        run("post_rst", 400, -1);
        r10 = 7'h41;
        run("blink_fc3", 5800, -1);
        r10 = 7'h21;
        run("blink_off", 700, -1);
        r10 = 7'h61;
        run("blink_fc4", 11300, -1);
        spec_cfg();
        r0 = 8'd40; r2 = 8'd20; r3 = 4'd0; r5 = 5'd0;
        run("hsw16_noadj", 2700, -1);
        spec_cfg();
        r2 = 8'd12; r7 = 7'd9;
        run("degenerate", 800, -1);
        spec_cfg();
        r2 = 8'd9; r3 = 4'd4;
        run("hs_wrap", 400, -1);
        spec_cfg();
        r0 = 8'd5; r2 = 8'd2; r3 = 4'd0; r4 = 7'd0; r9 = 5'd0; r5 = 5'd0; r7 = 7'd0;
        run("overlap", 300, -1);
        for (int i = 0; i < 8; i++) begin
            r0  = 8'($urandom_range(3, 20));
            r1  = 8'($urandom_range(0, int'(r0) + 2));
            r2  = 8'($urandom_range(0, int'(r0) + 2));
            r3  = 4'($urandom_range(0, 15));
            r4  = 7'($urandom_range(0, 6));
            r5  = 5'($urandom_range(0, 3));
            r6  = 7'($urandom_range(0, int'(r4) + 2));
            r7  = 7'($urandom_range(0, int'(r4) + 1));
            r9  = 5'($urandom_range(0, 3));
            r10 = 7'($urandom);
            r11 = 5'($urandom_range(0, 4));
            r12 = 14'($urandom);
            r14 = r12 + 14'($urandom_range(0, 20));
            cyc = 3 * ((int'(r4) + 1) * (int'(r9) + 1) + int'(r5)) * (int'(r0) + 1);
            run($sformatf("rand%0d", i), (cyc > 3000) ? 3000 : cyc, -1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
